// File: rtl/gf2_div21.sv
// GF(2) polynomial long divider: 21-bit dividend by 11-bit divisor, one quotient
// bit position per cycle, producing quotient, remainder and a divide-by-zero flag.
module gf2_div21 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [20:0] n,
  input  logic [10:0] dvs,
  output logic        busy,
  output logic        done,
  output logic [20:0] q,
  output logic [9:0]  r,
  output logic        err
);

  localparam int unsigned NW  = 21;
  localparam int unsigned DW  = 11;
  localparam int unsigned RW  = 10;
  localparam int unsigned KW  = 5;
  localparam int unsigned DGW = 4;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   w_q, w_d;
  logic [NW-1:0]   q_q, q_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DGW-1:0]  d_q, d_d;
  logic [KW-1:0]   k_q, k_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [DGW-1:0]  msb_c;
  logic [KW-1:0]   sh_c;
  logic [NW-1:0]   w_sh_c;

  // Priority encoder: index of the highest set divisor bit
  always_comb begin
    msb_c = '0;
    for (int i = 0; i < int'(DW); i++) begin
      if (dvs[i]) msb_c = DGW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    d_d     = d_q;
    k_d     = k_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sh_c    = k_q - KW'(d_q);
    w_sh_c  = w_q >> k_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dvs_d  = dvs;
          d_d    = msb_c;
          q_d    = '0;
          k_d    = KW'(NW - 1);
          err_d  = (dvs == '0);
          // A zero divisor skips the division; W is cleared so r reports 0
          if (dvs == '0) begin
            w_d     = '0;
            state_d = DONE;
          end else begin
            w_d     = n;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if ((k_q >= KW'(d_q)) && w_sh_c[0]) begin
          w_d = w_q ^ (NW'(dvs_q) << sh_c);
          q_d = q_q | (NW'(1) << sh_c);
        end
        if (k_q == '0) begin
          state_d = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      d_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      d_q     <= d_d;
      k_q     <= k_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = w_q[RW-1:0];
  assign err  = err_q;

endmodule

// File: doc/gf2_div21.md
GF2_DIV21 -- requirements
Module: gf2_div21

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 21-bit dividend, 11-bit divisor.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 n  input  21  dividend polynomial over GF(2); bit i is the coefficient of x^i.
REQ-006 dvs  input  11  divisor polynomial over GF(2); bit i is the coefficient of x^i.
REQ-007 busy  output  1  high while a request is in progress (states DIV and DONE).
REQ-008 done  output  1  one-cycle pulse; q, r and err are valid in that cycle.
REQ-009 q  output  21  quotient polynomial.
REQ-010 r  output  10  remainder polynomial; degree is less than deg(dvs).
REQ-011 err  output  1  divide-by-zero flag for the last completed request.

Function
REQ-012 The block SHALL compute q and r such that q·dvs XOR r = n, with polynomial multiplication carry-less over GF(2) and deg r < deg dvs.
REQ-013 The FSM SHALL have three states: IDLE, DIV and DONE.
- IDLE -> DIV on start with dvs != 0.
- IDLE -> DONE on start with dvs == 0.
- DIV -> DONE after exactly 21 DIV cycles.
- DONE -> IDLE unconditionally.
REQ-014 On accepting start, the block SHALL capture n into a 21-bit working register W.
REQ-015 On accepting start, the block SHALL capture dvs and latch d = index of the most significant set bit of dvs, using a priority encoder.
REQ-016 On accepting start, the block SHALL clear the quotient register and load step counter k = 20.
REQ-017 In each DIV cycle, if k >= d and W[k] = 1, the block SHALL set W = W XOR (dvs << (k-d)) and set q[k-d] = 1; otherwise W and q SHALL hold.
- k SHALL decrement by 1 each DIV cycle.
- DIV SHALL exit after the cycle with k = 0.
REQ-018 Latency SHALL be fixed: when start is accepted at edge T, done SHALL be high in the cycle after edge T+22 for dvs != 0, and after edge T+1 for dvs == 0.
REQ-019 In DONE, r SHALL equal W[9:0]; W[20:10] SHALL be zero by construction.
REQ-020 q, r and err SHALL hold their values after DONE until the next accepted start.
REQ-021 In DONE with dvs == 0, the block SHALL output err = 1, q = 0 and r = 0.
REQ-022 In DONE with dvs != 0, the block SHALL output err = 0.
REQ-023 start while busy = 1 SHALL be ignored, with no effect on the in-flight operation.
REQ-024 n and dvs SHALL be don't-care after the accepting edge; the block SHALL use only its captured copies.
REQ-025 busy SHALL rise on the edge that accepts start and fall on the edge leaving DONE.
REQ-026 start held high continuously SHALL start a new request on the first IDLE cycle after DONE, so back-to-back requests are spaced 23 cycles apart.
REQ-027 Divisor degree 0 (dvs = 1) SHALL yield q = n and r = 0.
REQ-028 Divisor degree 10 SHALL yield q of at most 11 significant bits.

Reset
REQ-029 While rst = 1 at a clock edge, the block SHALL go to state IDLE.
REQ-030 Reset SHALL force busy = 0, done = 0, err = 0, q = 0, r = 0, W = 0 and k = 0.
REQ-031 Reset SHALL take priority over start and over any in-progress state.
REQ-032 Reset in DIV or DONE SHALL abort the operation with no done pulse.
REQ-033 A start presented in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-034 The bench SHALL cover n = 21'h000005, dvs = 11'h003 -> done after 22 cycles with q = 21'h000003, r = 10'h000, err = 0.
REQ-035 The bench SHALL cover n = 21'h000007, dvs = 11'h002 -> q = 21'h000003, r = 10'h001.
REQ-036 The bench SHALL cover n = 21'h1FFFFF at both divisor-degree extremes:
- dvs = 11'h400 -> q = 21'h0007FF, r = 10'h3FF.
- dvs = 11'h001 -> q = 21'h1FFFFF, r = 10'h000.
REQ-037 The bench SHALL cover dvs = 11'h000 with any n -> done one cycle after acceptance with err = 1, q = 0, r = 0; a following request then reports err = 0.
REQ-038 The bench SHALL assert rst at DIV cycle 10 -> no done pulse and all outputs 0; a new start then completes correctly with full latency.
REQ-039 The bench SHALL run 10k random (n, dvs != 0) requests, with start randomly pulsed while busy, checking:
- q·dvs XOR r == n using a carry-less multiply model;
- deg r < deg dvs;
- done pulses exactly once per accepted start.
